// File: rtl/mux2_1_sync.sv
// mux2_1_sync: width-parameterised 2:1 multiplexer with a zero-latency
// combinational result and a registered observation path for downstream
// logic and debug.
//
// Parameters:
//   WIDTH  data width of in1, in2, out, out_q
//   CNT_W  width of the saturating select-switch counter
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (registered path only)
//   in1           data chosen when select = 0
//   in2           data chosen when select = 1
//   select        selection line
//   out           combinational mux result, independent of clk and rst
//   out_q         out registered on clk
//   sel_q         select registered on clk
//   sel_change    one-cycle pulse when the sampled select differs from sel_q
//   switch_count  select transitions since reset, saturating at all-ones
module mux2_1_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_change,
  output logic [CNT_W-1:0] switch_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Steering path. The conditional operator gives no priority to either input:
  // an unknown select yields X on every bit where in1 and in2 disagree.
  assign out = select ? in2 : in1;

  // Edge detect against the previously registered select.
  logic sel_diff;
  assign sel_diff = (select != sel_q);

  // Registered observation path; reset overrides every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      sel_q        <= 1'b0;
      sel_change   <= 1'b0;
      switch_count <= '0;
    end else begin
      out_q      <= out;
      sel_q      <= select;
      sel_change <= sel_diff;
      if (sel_diff && (switch_count != CNT_MAX)) begin
        switch_count <= switch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux2_1_sync.sv
// Directed testbench for mux2_1_sync: a 1-bit/8-bit-counter instance and an
// 8-bit/2-bit-counter instance share clk, rst and select.
module tb_mux2_1_sync;

  logic       clk;
  logic       rst;
  logic       select;

  logic       in1_a, in2_a, out_a, out_q_a, sel_q_a, sel_change_a;
  logic [7:0] count_a;

  logic [7:0] in1_b, in2_b, out_b, out_q_b;
  logic       sel_q_b, sel_change_b;
  logic [1:0] count_b;

  int n_cmp;
  int n_err;

  mux2_1_sync #(.WIDTH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in1(in1_a), .in2(in2_a), .select(select),
    .out(out_a), .out_q(out_q_a), .sel_q(sel_q_a),
    .sel_change(sel_change_a), .switch_count(count_a)
  );

  mux2_1_sync #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in1(in1_b), .in2(in2_b), .select(select),
    .out(out_b), .out_q(out_q_b), .sel_q(sel_q_b),
    .sel_change(sel_change_b), .switch_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; select = 1'b0;
    in1_a = 1'b0; in2_a = 1'b0; in1_b = 8'h00; in2_b = 8'h00;
    tick(); tick();
    n_cmp++; if (out_q_a !== 1'b0) begin n_err++; $display("FAIL reset_out_q_a got %b want 0", out_q_a); end
    n_cmp++; if (sel_q_a !== 1'b0) begin n_err++; $display("FAIL reset_sel_q_a got %b want 0", sel_q_a); end
    n_cmp++; if (sel_change_a !== 1'b0) begin n_err++; $display("FAIL reset_sel_change_a got %b want 0", sel_change_a); end
    n_cmp++; if (count_a !== 8'd0) begin n_err++; $display("FAIL reset_count_a got %0d want 0", count_a); end
    n_cmp++; if (out_q_b !== 8'h00) begin n_err++; $display("FAIL reset_out_q_b got %h want 00", out_q_b); end
    n_cmp++; if (count_b !== 2'd0) begin n_err++; $display("FAIL reset_count_b got %0d want 0", count_b); end
  endtask

  // Runs with rst still high: the combinational path must ignore reset.
  task automatic test_comb();
    in1_a = 1'b0; in2_a = 1'b0; select = 1'b0; #1;
    n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL comb_000 got %b want 0", out_a); end
    in1_a = 1'b1; #1;
    n_cmp++; if (out_a !== 1'b1) begin n_err++; $display("FAIL comb_in1 got %b want 1", out_a); end
    select = 1'b1; #1;
    n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL comb_sel_in2 got %b want 0", out_a); end
    in2_a = 1'b1; #1;
    n_cmp++; if (out_a !== 1'b1) begin n_err++; $display("FAIL comb_in2 got %b want 1", out_a); end
    select = 1'b0; in1_a = 1'b0; #1;
    n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL comb_back_in1 got %b want 0", out_a); end
  endtask

  task automatic test_registered();
    rst = 1'b0; in1_a = 1'b1; in2_a = 1'b0; select = 1'b0;
    tick();
    n_cmp++; if (out_q_a !== 1'b1) begin n_err++; $display("FAIL reg_out_q got %b want 1", out_q_a); end
    n_cmp++; if (sel_change_a !== 1'b0) begin n_err++; $display("FAIL reg_first_sel0_change got %b want 0", sel_change_a); end
    n_cmp++; if (count_a !== 8'd0) begin n_err++; $display("FAIL reg_first_sel0_count got %0d want 0", count_a); end
  endtask

  task automatic test_toggle();
    select = 1'b1; tick();
    n_cmp++; if (sel_q_a !== 1'b1) begin n_err++; $display("FAIL tog1_sel_q got %b want 1", sel_q_a); end
    n_cmp++; if (sel_change_a !== 1'b1) begin n_err++; $display("FAIL tog1_change got %b want 1", sel_change_a); end
    n_cmp++; if (count_a !== 8'd1) begin n_err++; $display("FAIL tog1_count got %0d want 1", count_a); end
    n_cmp++; if (out_q_a !== 1'b0) begin n_err++; $display("FAIL tog1_out_q got %b want 0", out_q_a); end
    select = 1'b0; tick();
    n_cmp++; if (sel_change_a !== 1'b1) begin n_err++; $display("FAIL tog2_change got %b want 1", sel_change_a); end
    n_cmp++; if (count_a !== 8'd2) begin n_err++; $display("FAIL tog2_count got %0d want 2", count_a); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (sel_change_a !== 1'b0) begin n_err++; $display("FAIL hold%0d_change got %b want 0", i, sel_change_a); end
      n_cmp++; if (count_a !== 8'd2) begin n_err++; $display("FAIL hold%0d_count got %0d want 2", i, count_a); end
    end
  endtask

  task automatic test_saturation();
    int exp_b [5] = '{1, 2, 3, 3, 3};
    int exp_a [5] = '{1, 2, 3, 4, 5};
    rst = 1'b1; select = 1'b0; tick();
    rst = 1'b0; tick();
    n_cmp++; if (count_b !== 2'd0) begin n_err++; $display("FAIL sat_start got %0d want 0", count_b); end
    for (int i = 0; i < 5; i++) begin
      select = ~select; tick();
      n_cmp++; if (count_b !== 2'(exp_b[i])) begin n_err++; $display("FAIL sat%0d_count_b got %0d want %0d", i, count_b, exp_b[i]); end
      n_cmp++; if (count_a !== 8'(exp_a[i])) begin n_err++; $display("FAIL sat%0d_count_a got %0d want %0d", i, count_a, exp_a[i]); end
      n_cmp++; if (sel_change_b !== 1'b1) begin n_err++; $display("FAIL sat%0d_change got %b want 1", i, sel_change_b); end
    end
  endtask

  // Entered with select=1, sel_q=1 and count_b saturated at 3.
  task automatic test_mid_reset();
    in1_b = 8'h11; in2_b = 8'h22; rst = 1'b1; #1;
    n_cmp++; if (out_b !== 8'h22) begin n_err++; $display("FAIL mrst_out_before got %h want 22", out_b); end
    tick();
    n_cmp++; if (out_q_b !== 8'h00) begin n_err++; $display("FAIL mrst_out_q got %h want 00", out_q_b); end
    n_cmp++; if (sel_q_b !== 1'b0) begin n_err++; $display("FAIL mrst_sel_q got %b want 0", sel_q_b); end
    n_cmp++; if (sel_change_b !== 1'b0) begin n_err++; $display("FAIL mrst_change got %b want 0", sel_change_b); end
    n_cmp++; if (count_b !== 2'd0) begin n_err++; $display("FAIL mrst_count got %0d want 0", count_b); end
    n_cmp++; if (count_a !== 8'd0) begin n_err++; $display("FAIL mrst_count_a got %0d want 0", count_a); end
    n_cmp++; if (out_b !== 8'h22) begin n_err++; $display("FAIL mrst_out_during got %h want 22", out_b); end
    rst = 1'b0; tick();
    n_cmp++; if (sel_change_b !== 1'b1) begin n_err++; $display("FAIL first_sel1_change got %b want 1", sel_change_b); end
    n_cmp++; if (count_b !== 2'd1) begin n_err++; $display("FAIL first_sel1_count got %0d want 1", count_b); end
    n_cmp++; if (out_q_b !== 8'h22) begin n_err++; $display("FAIL first_sel1_out_q got %h want 22", out_q_b); end
  endtask

  task automatic test_wide();
    select = 1'b0; in1_b = 8'hA5; in2_b = 8'h3C; #1;
    n_cmp++; if (out_b !== 8'hA5) begin n_err++; $display("FAIL wide_out_sel0 got %h want a5", out_b); end
    tick();
    n_cmp++; if (out_q_b !== 8'hA5) begin n_err++; $display("FAIL wide_out_q_sel0 got %h want a5", out_q_b); end
    select = 1'b1; #1;
    n_cmp++; if (out_b !== 8'h3C) begin n_err++; $display("FAIL wide_out_sel1 got %h want 3c", out_b); end
    n_cmp++; if (out_q_b !== 8'hA5) begin n_err++; $display("FAIL wide_out_q_hold got %h want a5", out_q_b); end
    tick();
    n_cmp++; if (out_q_b !== 8'h3C) begin n_err++; $display("FAIL wide_out_q_sel1 got %h want 3c", out_q_b); end
    n_cmp++; if (sel_q_b !== 1'b1) begin n_err++; $display("FAIL wide_sel_q got %b want 1", sel_q_b); end
  endtask

  // Data and select change together: out follows at once, out_q takes the pre-edge out.
  task automatic test_back_to_back();
    select = 1'b0; in1_b = 8'h5A; in2_b = 8'hFF; #1;
    n_cmp++; if (out_b !== 8'h5A) begin n_err++; $display("FAIL b2b_out got %h want 5a", out_b); end
    n_cmp++; if (out_q_b !== 8'h3C) begin n_err++; $display("FAIL b2b_out_q_pre got %h want 3c", out_q_b); end
    tick();
    n_cmp++; if (out_q_b !== 8'h5A) begin n_err++; $display("FAIL b2b_out_q got %h want 5a", out_q_b); end
    n_cmp++; if (sel_change_b !== 1'b1) begin n_err++; $display("FAIL b2b_change got %b want 1", sel_change_b); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_comb();
    test_registered();
    test_toggle();
    test_saturation();
    test_mid_reset();
    test_wide();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
